// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, ALUOp classes and FSM states.
// Imported by the execute-stage ALU and its multiplier.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SLL = 4'd3;
  localparam logic [3:0] OP_SRL = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic {
    S_IDLE,
    S_MUL_RUN
  } state_t;

  function automatic logic [1:0] alu_class(input logic [3:0] op);
    logic [1:0] c;
    case (op)
      OP_ADD:         c = ALUOP_ADD;
      OP_SUB, OP_SLT: c = ALUOP_SUB;
      default:        c = ALUOP_RTYPE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier, BITS multiplier bits per cycle.
// done/product are valid combinationally in the last step cycle.
module mul_iter
  import alu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int BITS   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              running,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int STEPS = DATA_W / BITS;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] partial;
  logic [DATA_W-1:0] acc_nxt;
  logic [CNT_W-1:0]  cnt;

  // partial product of the low BITS multiplier bits
  always_comb begin
    partial = '0;
    for (int i = 0; i < BITS; i++) begin
      if (mplier[i]) partial = partial + (mcand << i);
    end
    acc_nxt = acc + partial;
  end

  assign done    = running & (cnt == CNT_W'(STEPS - 1));
  assign product = acc_nxt;

  // accumulator, shifted operands and step counter
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      running <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      acc     <= '0;
      mcand   <= a;
      mplier  <= b;
      cnt     <= '0;
    end else if (running) begin
      acc    <= acc_nxt;
      mcand  <= mcand << BITS;
      mplier <= mplier >> BITS;
      cnt    <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: 1-cycle logic/arith/shift/compare, iterative MUL.
// Results are registered and qualified by a one-cycle out_valid pulse.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int DATA_W         = 64,
  parameter int MUL_BITS_PER_C = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] alu_in_0,
  input  logic [DATA_W-1:0] alu_in_1,
  output logic              out_valid,
  output logic [DATA_W-1:0] alu_out,
  output logic              zero_flag,
  output logic              busy
);

  localparam int SH_W = $clog2(DATA_W);

  state_t state, state_nxt;

  logic              accept;
  logic              is_mul;
  logic              sub;
  logic              mul_start;
  logic              mul_done;
  logic              mul_run;
  logic              load_comb;
  logic              load_mul;
  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] addsub;
  logic [DATA_W-1:0] comb_res;
  logic [DATA_W-1:0] mul_prod;

  assign in_ready = (state == S_IDLE) & ~rst;
  assign accept   = in_valid & in_ready & ~flush;
  assign is_mul   = (alu_control == OP_MUL);
  assign sub      = (alu_class(alu_control) == ALUOP_SUB);
  assign shamt    = alu_in_1[SH_W-1:0];
  assign busy     = (state == S_MUL_RUN);

  // single-cycle datapath
  always_comb begin
    addsub = alu_in_0 + (sub ? ~alu_in_1 : alu_in_1)
           + {{(DATA_W-1){1'b0}}, sub};
    comb_res = '0;
    case (alu_control)
      OP_AND: comb_res = alu_in_0 & alu_in_1;
      OP_OR:  comb_res = alu_in_0 | alu_in_1;
      OP_ADD: comb_res = addsub;
      OP_SUB: comb_res = addsub;
      OP_SLL: comb_res = alu_in_0 << shamt;
      OP_SRL: comb_res = alu_in_0 >> shamt;
      OP_SLT: comb_res = {{(DATA_W-1){1'b0}},
                          $signed(alu_in_0) < $signed(alu_in_1)};
      default: comb_res = '0;
    endcase
  end

  mul_iter #(
    .DATA_W (DATA_W),
    .BITS   (MUL_BITS_PER_C)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .abort   (flush),
    .a       (alu_in_0),
    .b       (alu_in_1),
    .running (mul_run),
    .done    (mul_done),
    .product (mul_prod)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next state and load strobes
  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    load_comb = 1'b0;
    load_mul  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_mul) begin
            mul_start = 1'b1;
            state_nxt = S_MUL_RUN;
          end else begin
            load_comb = 1'b1;
          end
        end
      end
      S_MUL_RUN: begin
        if (flush) begin
          state_nxt = S_IDLE;
        end else if (mul_done && mul_run) begin
          load_mul  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // result registers, held until the next result
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_out   <= '0;
      zero_flag <= 1'b1;
    end else begin
      out_valid <= load_comb | load_mul;
      if (load_comb) begin
        alu_out   <= comb_res;
        zero_flag <= (comb_res == '0);
      end else if (load_mul) begin
        alu_out   <= mul_prod;
        zero_flag <= (mul_prod == '0);
      end
    end
  end

endmodule
